// File: rtl/sr_iter.sv
// sr_iter: iterative 32-bit right shifter for the multi-cycle ALU path.
// A start pulse captures operand, amount and fill mode. Each clock then
// retires up to 4 bit positions through a registered 4/2/1 right-shift
// datapath. Completion is signalled by a one-cycle data_resultRDY pulse.
// Optional feature: define SR_ITER_ARITH_EN to honour ctrl_arith (sign fill).
// When it is undefined, ctrl_arith is ignored and every shift is logical.
module sr_iter (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_shift,
   input  logic [31:0] data_operandA,
   input  logic [4:0]  ctrl_shiftamt,
   input  logic        ctrl_arith,
   output logic [31:0] data_result,
   output logic        data_resultRDY,
   output logic        busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]  state;
   logic [31:0] work;
   logic [4:0]  remaining;
   logic        fill;

   logic [2:0]  step_amt;
   logic [31:0] shift4;
   logic [31:0] shift2;
   logic [31:0] shift1;
   logic [4:0]  rem_next;
   logic        accept;

   assign accept = (state == IDLE) && ctrl_shift;
   assign busy   = (state == SHIFT);

`ifdef SR_ITER_ARITH_EN
   // Fill bit captured at accept; it feeds every vacated MSB until completion.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fill <= 1'b0;
      end else if (accept) begin
         fill <= ctrl_arith & data_operandA[31];
      end
   end
`else
   logic unused_arith;
   assign unused_arith = ctrl_arith;
   assign fill         = 1'b0;
`endif

   // Per-step shift amount: a full 4 while at least 4 remain, otherwise the
   // leftover 0..3 (0 only when the requested amount itself was 0).
   always_comb begin
      step_amt = 3'd0;
      if (remaining >= 5'd4) begin
         step_amt = 3'd4;
      end else begin
         step_amt = {1'b0, remaining[1:0]};
      end
   end

   // 4/2/1 right-shift chain applied to the working register.
   always_comb begin
      shift4 = work;
      shift2 = work;
      shift1 = work;
      if (step_amt[2]) begin
         shift4 = {{4{fill}}, work[31:4]};
      end
      shift2 = shift4;
      if (step_amt[1]) begin
         shift2 = {{2{fill}}, shift4[31:2]};
      end
      shift1 = shift2;
      if (step_amt[0]) begin
         shift1 = {fill, shift2[31:1]};
      end
   end

   assign rem_next = remaining - {2'b00, step_amt};

   // Control FSM and working-register update; result and ready pulse are
   // produced on the step that exhausts the remaining amount.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         work           <= 32'd0;
         remaining      <= 5'd0;
         data_result    <= 32'd0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (ctrl_shift) begin
                  work      <= data_operandA;
                  remaining <= ctrl_shiftamt;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               work      <= shift1;
               remaining <= rem_next;
               if (rem_next == 5'd0) begin
                  data_result    <= shift1;
                  data_resultRDY <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_iter.sv
// tb_sr_iter: scoreboard bench for sr_iter. Expected results are computed by
// a reference shift model when a start is driven, queued, and popped when
// the DUT pulses data_resultRDY.
module tb_sr_iter;

   logic        clock;
   logic        reset;
   logic        ctrl_shift;
   logic [31:0] data_operandA;
   logic [4:0]  ctrl_shiftamt;
   logic        ctrl_arith;
   logic [31:0] data_result;
   logic        data_resultRDY;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      int          steps;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_err;

   sr_iter dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_shift     (ctrl_shift),
      .data_operandA  (data_operandA),
      .ctrl_shiftamt  (ctrl_shiftamt),
      .ctrl_arith     (ctrl_arith),
      .data_result    (data_result),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: sign fill done by complementing around a logical shift.
   function automatic exp_t model(input logic [31:0] op, input logic [4:0] amt,
                                  input logic arith);
      exp_t e;
      logic fill;
`ifdef SR_ITER_ARITH_EN
      fill = arith & op[31];
`else
      fill = 1'b0;
      if (arith) fill = 1'b0;
`endif
      if (fill) e.res = ~((~op) >> amt);
      else      e.res = op >> amt;
      e.steps = (amt == 5'd0) ? 1 : (int'(amt) + 3) / 4;
      return e;
   endfunction

   // Drive one start pulse (sampled at the next edge) and queue its result.
   task automatic start_op(input logic [31:0] op, input logic [4:0] amt,
                           input logic arith);
      data_operandA = op;
      ctrl_shiftamt = amt;
      ctrl_arith    = arith;
      ctrl_shift    = 1'b1;
      sb.push_back(model(op, amt, arith));
      @(posedge clock);
      #1;
      ctrl_shift    = 1'b0;
      data_operandA = $urandom;
      ctrl_shiftamt = 5'($urandom_range(0, 31));
      ctrl_arith    = 1'($urandom_range(0, 1));
   endtask

   // Wait (bounded) for the ready pulse; reports edges waited and busy samples.
   task automatic wait_ready(output int cyc, output int busy_cnt);
      cyc      = 0;
      busy_cnt = 0;
      while (!data_resultRDY && cyc < 20) begin
         if (busy) busy_cnt++;
         @(posedge clock);
         #1;
         cyc++;
      end
   endtask

   task automatic pop_exp(output exp_t e);
      e.res   = 32'hxxxxxxxx;
      e.steps = -1;
      if (sb.size() != 0) e = sb.pop_front();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ctrl_shift = 1'b0;
      data_operandA = 32'd0;
      ctrl_shiftamt = 5'd0;
      ctrl_arith = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_cmp++;
      if (data_resultRDY !== 1'b0) begin
         n_err++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
      end
      n_cmp++;
      if (data_result !== 32'd0) begin
         n_err++; $display("FAIL reset_result: got %h want 00000000", data_result);
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_basic();
      int cyc, bc;
      exp_t e;
      start_op(32'h12345678, 5'd4, 1'b0);
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 1 || e.steps !== 1) begin
         n_err++; $display("FAIL basic_latency: got %0d want 1", cyc);
      end
      n_cmp++;
      if (bc !== 1) begin
         n_err++; $display("FAIL basic_busy_cycles: got %0d want 1", bc);
      end
      n_cmp++;
      if (data_result !== 32'h01234567) begin
         n_err++; $display("FAIL basic_result: got %h want 01234567", data_result);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL basic_busy_at_ready: got %b want 0", busy);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (data_resultRDY !== 1'b0 || data_result !== 32'h01234567) begin
         n_err++; $display("FAIL basic_hold: got rdy=%b res=%h want rdy=0 res=01234567",
                           data_resultRDY, data_result);
      end
   endtask

   task automatic test_amt31();
      int cyc, bc;
      exp_t e;
      logic [31:0] want_arith;
`ifdef SR_ITER_ARITH_EN
      want_arith = 32'hFFFFFFFF;
`else
      want_arith = 32'h00000001;
`endif
      start_op(32'h80000000, 5'd31, 1'b0);
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 8) begin
         n_err++; $display("FAIL amt31_logic_latency: got %0d want 8", cyc);
      end
      n_cmp++;
      if (data_result !== 32'h00000001 || e.res !== 32'h00000001) begin
         n_err++; $display("FAIL amt31_logic_result: got %h want 00000001", data_result);
      end
      @(posedge clock);
      #1;
      start_op(32'h80000000, 5'd31, 1'b1);
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 8 || bc !== 8) begin
         n_err++; $display("FAIL amt31_arith_latency: got %0d/%0d want 8/8", cyc, bc);
      end
      n_cmp++;
      if (data_result !== want_arith) begin
         n_err++; $display("FAIL amt31_arith_result: got %h want %h", data_result, want_arith);
      end
   endtask

   task automatic test_zero_and_fill();
      int cyc, bc;
      exp_t e;
      logic [31:0] want_fill;
`ifdef SR_ITER_ARITH_EN
      want_fill = 32'hFF800000;
`else
      want_fill = 32'h07800000;
`endif
      @(posedge clock);
      #1;
      start_op(32'hDEADBEEF, 5'd0, 1'b1);
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 1) begin
         n_err++; $display("FAIL amt0_latency: got %0d want 1", cyc);
      end
      n_cmp++;
      if (data_result !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL amt0_result: got %h want deadbeef", data_result);
      end
      @(posedge clock);
      #1;
      start_op(32'hF0000000, 5'd5, 1'b1);
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 2) begin
         n_err++; $display("FAIL amt5_latency: got %0d want 2", cyc);
      end
      n_cmp++;
      if (data_result !== want_fill) begin
         n_err++; $display("FAIL amt5_result: got %h want %h", data_result, want_fill);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bc;
      exp_t e;
      @(posedge clock);
      #1;
      start_op(32'h0000FFFF, 5'd16, 1'b0);
      // Hold a competing start asserted for every edge while busy.
      data_operandA = 32'hAAAAAAAA;
      ctrl_shiftamt = 5'd1;
      ctrl_arith    = 1'b0;
      ctrl_shift    = 1'b1;
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 4 || bc !== 4) begin
         n_err++; $display("FAIL b2b_first_latency: got %0d/%0d want 4/4", cyc, bc);
      end
      n_cmp++;
      if (data_result !== 32'h00000000 || e.res !== 32'h00000000) begin
         n_err++; $display("FAIL b2b_first_result: got %h want 00000000", data_result);
      end
      // The still-asserted start is sampled at the edge after the ready cycle.
      sb.push_back(model(32'hAAAAAAAA, 5'd1, 1'b0));
      @(posedge clock);
      #1;
      ctrl_shift = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || data_result !== 32'h00000000) begin
         n_err++; $display("FAIL b2b_accept: got busy=%b res=%h want busy=1 res=00000000",
                           busy, data_result);
      end
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== e.steps) begin
         n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", cyc, e.steps);
      end
      n_cmp++;
      if (data_result !== 32'h55555555) begin
         n_err++; $display("FAIL b2b_second_result: got %h want 55555555", data_result);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, bc, pulses;
      exp_t e;
      @(posedge clock);
      #1;
      start_op(32'h7FFF0000, 5'd20, 1'b0);
      @(posedge clock);
      #1;
      @(posedge clock);
      #2;
      reset = 1'b1;
      sb.delete();
      #1;
      n_cmp++;
      if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
         n_err++; $display("FAIL midreset_ctrl: got busy=%b rdy=%b want 0/0", busy, data_resultRDY);
      end
      n_cmp++;
      if (data_result !== 32'd0) begin
         n_err++; $display("FAIL midreset_result: got %h want 00000000", data_result);
      end
      #1;
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY || busy) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_err++; $display("FAIL midreset_no_pulse: got %0d active cycles want 0", pulses);
      end
      start_op(32'h87654321, 5'd7, 1'b1);
      wait_ready(cyc, bc);
      pop_exp(e);
      n_cmp++;
      if (cyc !== 2 || data_result !== e.res) begin
         n_err++; $display("FAIL midreset_fresh: got %0d/%h want 2/%h", cyc, data_result, e.res);
      end
   endtask

   task automatic test_random();
      int cyc, bc;
      exp_t e;
      logic [31:0] op;
      logic [4:0]  amt;
      logic        ar;
      for (int i = 0; i < 12; i++) begin
         op  = $urandom;
         amt = 5'($urandom_range(0, 31));
         ar  = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         start_op(op, amt, ar);
         wait_ready(cyc, bc);
         pop_exp(e);
         n_cmp++;
         if (cyc !== e.steps || bc !== e.steps || data_result !== e.res) begin
            n_err++;
            $display("FAIL random_%0d: op=%h amt=%0d ar=%b got %0d/%0d/%h want %0d/%h",
                     i, op, amt, ar, cyc, bc, data_result, e.steps, e.res);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_amt31();
      test_zero_and_fill();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sr_iter.md
# sr_iter

Iterative 32-bit right shifter for the ALU's multi-cycle path, the right-shift counterpart of the combinational left-shift stages. It accepts an operand and a 5-bit shift amount on a start pulse. It retires up to 4 bit positions per clock through a registered 4/2/1 right-shift datapath. It then presents the result with a one-cycle ready pulse to the writeback/stall logic.

## Interface
- No parameters; width fixed at 32, shift amount fixed at 5 bits.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ctrl_shift  input  1  start pulse; sampled at a rising edge while not busy
- data_operandA  input  32  value to shift; captured on accepted start
- ctrl_shiftamt  input  5  shift amount 0..31; captured on accepted start
- ctrl_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on accepted start; see Configuration
- data_result  output  32  shifted value; held stable from ready pulse until next accepted start completes
- data_resultRDY  output  1  one-cycle pulse, result valid
- busy  output  1  high while an operation is in progress

## Operation
- States: IDLE, SHIFT.
- IDLE: on an edge with ctrl_shift=1, capture the operand into the working register.
  - Capture remaining = ctrl_shiftamt and fill = (ctrl_arith & data_operandA[31]).
  - Go to SHIFT.
- SHIFT, each edge, one step:
  - remaining >= 4: shift right by 4, remaining -= 4.
  - 1 <= remaining <= 3: shift right by remaining, remaining = 0.
  - remaining = 0: zero-position shift.
- Vacated MSBs take the captured fill bit on every step.
- After the step that leaves remaining = 0:
  - copy the working register to data_result;
  - pulse data_resultRDY;
  - return to IDLE.
- Step count S = max(1, ceil(amt/4)). Examples: amt 0 gives S=1, amt 4 gives S=1, amt 5 gives S=2, amt 31 gives S=8.
- busy = (state == SHIFT).
- ctrl_shift while busy is ignored. It does not restart the operation and does not queue.
- Operand, amount and ctrl_arith inputs may change freely after the accepting edge.
- Reset (asynchronous, any time, including mid-operation):
  - state IDLE, data_result = 0, data_resultRDY = 0, busy = 0;
  - working register and remaining = 0.
  - The in-flight operation is discarded and no ready pulse is generated for it.

## Timing
- Start accepted at edge N. busy is high from after edge N until after edge N+S.
- data_result updates and data_resultRDY = 1 after edge N+S, for exactly one cycle.
- Back-to-back operation: during the ready cycle the block is in IDLE, so a ctrl_shift sampled at edge N+S+1 is accepted. Throughput is S+1 cycles per operation.
- data_result holds its value until the next operation's completion edge. It does not change at start.
- Worst-case latency: 8 cycles (amt 31).

## Configuration
- Macro SR_ITER_ARITH_EN.
- Defined: ctrl_arith is honoured, and sign fill is captured as described above.
- Undefined: the ctrl_arith port remains present but is ignored. Fill is always 0, all shifts are logical, and the sign-fill logic is not synthesized.
- All timing is identical either way.

## Test plan
- Reset, then 0x12345678, amt 4, logical. Required: ready after exactly 1 step, data_result = 0x01234567, busy high for 1 cycle.
- 0x80000000, amt 31. Required: ready 8 cycles after accept. Result 0x00000001 logical; 0xFFFFFFFF arithmetic (SR_ITER_ARITH_EN defined); 0x00000001 with ctrl_arith=1 when the macro is undefined.
- 0xDEADBEEF, amt 0. Required: ready after 1 step, data_result = 0xDEADBEEF. Also 0xF0000000, amt 5, arithmetic: 2 steps, result 0xFF800000.
- Start 0x0000FFFF amt 16. Re-assert ctrl_shift with 0xAAAAAAAA amt 1 at every edge while busy. Required: the second start is ignored while busy, and data_result = 0x00000000 after 4 steps. A start sampled in the ready cycle is accepted: result 0x55555555 after 1 step.
- Assert reset asynchronously mid-operation (amt 20, after 2 steps), between edges. Required: busy and data_resultRDY drop immediately, data_result = 0, no ready pulse follows. A fresh start afterwards completes normally.
